// File: rtl/spi_master_ctrl_pkg.sv
// Shared types and constants for the SPI master controller.
package spi_master_ctrl_pkg;

  // SPI mode 0: idle-low clock, sample on the rising edge, MSB first.
  localparam bit SPI_CPOL     = 1'b0;
  localparam bit SPI_CPHA     = 1'b0;
  localparam bit SPI_MSB_FRST = 1'b1;

  localparam int BYTE_W = 8;
  localparam int BIT_W  = 3;
  localparam int NB_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOAD  = 3'd2,
    ST_LOW   = 3'd3,
    ST_HIGH  = 3'd4,
    ST_HOLD  = 3'd5,
    ST_GAP   = 3'd6
  } state_t;

  // Width of the half-period counter; never narrower than one bit.
  function automatic int tmr_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Byte-stream handshake and SPI pins of the master controller.
interface spi_master_ctrl_if;
  import spi_master_ctrl_pkg::*;

  logic              i_start;
  logic [NB_W-1:0]   i_num_bytes;
  logic              o_busy;
  logic              o_done;
  logic [BYTE_W-1:0] i_tx_data;
  logic              i_tx_valid;
  logic              o_tx_ready;
  logic [BYTE_W-1:0] o_rx_data;
  logic              o_rx_valid;
  logic              o_cs_b;
  logic              o_sclk;
  logic              o_mosi;
  logic              i_miso;

  modport master (
    input  i_start, i_num_bytes, i_tx_data, i_tx_valid, i_miso,
    output o_busy, o_done, o_tx_ready, o_rx_data, o_rx_valid,
           o_cs_b, o_sclk, o_mosi
  );

  modport slave (
    output i_start, i_num_bytes, i_tx_data, i_tx_valid, i_miso,
    input  o_busy, o_done, o_tx_ready, o_rx_data, o_rx_valid,
           o_cs_b, o_sclk, o_mosi
  );

endinterface

// File: rtl/spi_master_ctrl_halfper_timer.sv
// Loadable down-counter that marks the last clk cycle of an sclk half-period.
module spi_halfper_timer
  import spi_master_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_tick
);

  localparam int            W      = tmr_width(CLK_DIV);
  localparam logic [W-1:0]  RELOAD = W'(CLK_DIV - 1);

  logic [W-1:0] r_cnt;

  // Reload on every phase change, otherwise count down and rest at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= RELOAD;
    else if (r_cnt != '0)
      r_cnt <= r_cnt - W'(1);
  end

  assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: burst of 1..MAX_BYTES bytes under one chip select.
module spi_master_ctrl
  import spi_master_ctrl_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int MAX_BYTES = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  spi_master_ctrl_if.master bus
);

  localparam logic [NB_W-1:0] MAX_NB = NB_W'(MAX_BYTES);

  state_t            r_state, w_state_nxt;
  logic              r_cs_b, r_sclk, r_busy, r_done, r_rx_valid;
  logic [BYTE_W-1:0] r_rx_data, r_tx_sh, r_rx_sh;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [NB_W-1:0]   r_byte_cnt;
  logic              w_tick, w_tmr_load, w_nb_ok, w_accept, w_xfer;
  logic              w_rise, w_fall, w_last_bit, w_last_byte;

  // A start in the done cycle is dropped so IDLE lasts at least one cycle.
  assign w_nb_ok     = (bus.i_num_bytes != '0) && (bus.i_num_bytes <= MAX_NB);
  assign w_accept    = (r_state == ST_IDLE) && bus.i_start && w_nb_ok && !r_done;
  assign w_xfer      = (r_state == ST_LOAD) && bus.i_tx_valid;
  assign w_rise      = (r_state == ST_LOW)  && w_tick;
  assign w_fall      = (r_state == ST_HIGH) && w_tick;
  assign w_last_bit  = (r_bit_cnt == BIT_W'(BYTE_W - 1));
  assign w_last_byte = (r_byte_cnt == NB_W'(1));
  assign w_tmr_load  = (w_state_nxt != r_state);

  spi_halfper_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_tmr_load),
    .o_tick (w_tick)
  );

  // Next-state decode: each SPI phase lasts one half-period, LOAD waits for data.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_SETUP;
      ST_SETUP: if (w_tick)   w_state_nxt = ST_LOAD;
      ST_LOAD:  if (w_xfer)   w_state_nxt = ST_LOW;
      ST_LOW:   if (w_tick)   w_state_nxt = ST_HIGH;
      ST_HIGH: begin
        if (w_tick) begin
          if (!w_last_bit)     w_state_nxt = ST_LOW;
          else if (w_last_byte) w_state_nxt = ST_HOLD;
          else                 w_state_nxt = ST_LOAD;
        end
      end
      ST_HOLD:  if (w_tick)   w_state_nxt = ST_GAP;
      ST_GAP:   if (w_tick)   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register, pin registers, counters and the outgoing shift register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_cs_b     <= 1'b1;
      r_sclk     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_tx_sh    <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cs_b     <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_GAP);
      r_sclk     <= (w_state_nxt == ST_HIGH);
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_done     <= (r_state == ST_GAP) && (w_state_nxt == ST_IDLE);
      r_rx_valid <= w_fall && w_last_bit;
      if (w_fall && w_last_bit)
        r_rx_data <= r_rx_sh;
      // mosi is the MSB of this register; shift only between bits of a byte.
      if (w_xfer)
        r_tx_sh <= bus.i_tx_data;
      else if (w_fall && !w_last_bit)
        r_tx_sh <= {r_tx_sh[BYTE_W-2:0], 1'b0};
      if (w_fall)
        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
      if (w_accept)
        r_byte_cnt <= bus.i_num_bytes;
      else if (w_fall && w_last_bit)
        r_byte_cnt <= r_byte_cnt - NB_W'(1);
    end
  end

  // Incoming shift register, filled MSB first on each rising sclk.
  always_ff @(posedge i_clk) begin
    if (w_rise)
      r_rx_sh <= {r_rx_sh[BYTE_W-2:0], bus.i_miso};
  end

  assign bus.o_cs_b     = r_cs_b;
  assign bus.o_sclk     = r_sclk;
  assign bus.o_mosi     = r_tx_sh[BYTE_W-1];
  assign bus.o_busy     = r_busy;
  assign bus.o_done     = r_done;
  assign bus.o_tx_ready = (r_state == ST_LOAD);
  assign bus.o_rx_data  = r_rx_data;
  assign bus.o_rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: CLK_DIV=4 and CLK_DIV=1 instances.
module tb_spi_master_ctrl;
  import spi_master_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4, rst1;
  spi_master_ctrl_if if4();
  spi_master_ctrl_if if1();

  spi_master_ctrl #(.CLK_DIV(4), .MAX_BYTES(8)) u_dut4 (
    .i_clk(clk), .i_rst(rst4), .bus(if4.master));
  spi_master_ctrl #(.CLK_DIV(1), .MAX_BYTES(8)) u_dut1 (
    .i_clk(clk), .i_rst(rst1), .bus(if1.master));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  logic [7:0] exp4[$];
  logic [7:0] exp1[$];
  logic [7:0] txb [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Slave model: returns the bytes it received in the previous transaction
  // (power-up contents 95,00,...), shifting out on sclk falls, in on rises.
  bit         sl_en = 1'b0;
  logic [7:0] sl_buf [8] = '{8'h95, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] sl_out = 8'h00;
  logic [7:0] sl_in  = 8'h00;
  int         sl_idx = 0;
  int         sl_bit = 0;

  always @(negedge if4.o_cs_b) if (sl_en) begin
    sl_idx = 0; sl_bit = 0; sl_out = sl_buf[0];
  end
  always @(posedge if4.o_sclk) if (sl_en && !if4.o_cs_b) begin
    sl_in = {sl_in[6:0], if4.o_mosi};
    sl_bit++;
  end
  always @(negedge if4.o_sclk) if (sl_en && !if4.o_cs_b) begin
    if (sl_bit == 8) begin
      sl_buf[sl_idx] = sl_in;
      sl_idx++;
      sl_bit = 0;
      sl_out = (sl_idx < 8) ? sl_buf[sl_idx] : 8'h00;
    end else begin
      sl_out = {sl_out[6:0], 1'b0};
    end
  end

  assign if4.i_miso = sl_en ? (!if4.o_cs_b & sl_out[7]) : if4.o_mosi;
  assign if1.i_miso = if1.o_mosi;

  // Monitors: pop and compare on every rx_valid, count events.
  int   n_rxv4 = 0, n_done4 = 0, rises4 = 0, cslow4 = 0;
  logic prev_sclk4 = 1'b0;
  always @(negedge clk) begin
    if (if4.o_rx_valid) begin
      n_rxv4++;
      if (exp4.size() == 0) begin
        tests++; fails++;
        $display("FAIL rx4_unexpected: got %02h, expected no byte", if4.o_rx_data);
      end else
        chk("rx4_data", 32'(if4.o_rx_data), 32'(exp4.pop_front()));
    end
    if (if4.o_done) n_done4++;
    if (if4.o_sclk && !prev_sclk4) rises4++;
    if (!if4.o_cs_b) cslow4++;
    prev_sclk4 = if4.o_sclk;
  end

  int   n_rxv1 = 0, n_done1 = 0;
  int   rise1_cyc[$];
  logic prev_sclk1 = 1'b0;
  always @(negedge clk) begin
    if (if1.o_rx_valid) begin
      n_rxv1++;
      if (exp1.size() == 0) begin
        tests++; fails++;
        $display("FAIL rx1_unexpected: got %02h, expected no byte", if1.o_rx_data);
      end else
        chk("rx1_data", 32'(if1.o_rx_data), 32'(exp1.pop_front()));
    end
    if (if1.o_done) n_done1++;
    if (if1.o_sclk && !prev_sclk1) rise1_cyc.push_back(cyc);
    prev_sclk1 = if1.o_sclk;
  end

  task automatic wait_done4(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (if4.o_done) begin ok = 1'b1; break; end
    end
  endtask

  // One transaction on the CLK_DIV=4 instance; optional 20-cycle stall before byte stall_at.
  task automatic run4(input int n, input int stall_at);
    bit ok, bad;
    @(negedge clk);
    if4.i_num_bytes = 4'(n); if4.i_start = 1'b1;
    @(negedge clk);
    if4.i_start = 1'b0;
    chk("busy_after_start", 32'(if4.o_busy), 32'd1);
    chk("csb_after_start",  32'(if4.o_cs_b), 32'd0);
    for (int k = 0; k < n; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
        if (if4.o_tx_ready) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      if (!ok) begin chk("tx_ready_timeout", 32'd0, 32'd1); return; end
      if (k == stall_at) begin
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
          if (if4.o_sclk || if4.o_cs_b || !if4.o_tx_ready) bad = 1'b1;
          @(negedge clk);
        end
        chk("stall_sclk0_csb0", 32'(bad), 32'd0);
      end
      if4.i_tx_data = txb[k]; if4.i_tx_valid = 1'b1;
      @(negedge clk);
      if4.i_tx_valid = 1'b0;
    end
    wait_done4(ok);
    chk("done4_seen", 32'(ok), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int r0, c0, v0, d0, i0;
    bit ok, bad;
    if4.i_start = 1'b0; if4.i_num_bytes = '0; if4.i_tx_data = '0; if4.i_tx_valid = 1'b0;
    if1.i_start = 1'b0; if1.i_num_bytes = '0; if1.i_tx_data = '0; if1.i_tx_valid = 1'b0;
    rst4 = 1'b1; rst1 = 1'b1;
    repeat (3) @(negedge clk);
    rst4 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    chk("rst_cs_b",     32'(if4.o_cs_b),     32'd1);
    chk("rst_sclk",     32'(if4.o_sclk),     32'd0);
    chk("rst_mosi",     32'(if4.o_mosi),     32'd0);
    chk("rst_busy",     32'(if4.o_busy),     32'd0);
    chk("rst_tx_ready", 32'(if4.o_tx_ready), 32'd0);
    chk("rst_rx_data",  32'(if4.o_rx_data),  32'd0);
    chk("rst1_cs_b",    32'(if1.o_cs_b),     32'd1);

    // Loopback, one byte A5.
    txb[0] = 8'hA5; exp4.push_back(8'hA5);
    r0 = rises4; c0 = cslow4; v0 = n_rxv4; d0 = n_done4;
    run4(1, -1);
    @(negedge clk);
    chk("lb1_rises",   32'(rises4 - r0),  32'd8);
    // SETUP 4 + LOAD 1 + 16 half-periods of 4 + HOLD 4
    chk("lb1_cs_low",  32'(cslow4 - c0),  32'd73);
    chk("lb1_rxvalid", 32'(n_rxv4 - v0),  32'd1);
    chk("lb1_done",    32'(n_done4 - d0), 32'd1);
    chk("lb1_busy_end", 32'(if4.o_busy), 32'd0);

    // Against the slave model: two full 8-byte bursts.
    sl_en = 1'b1;
    for (int i = 0; i < 8; i++) txb[i] = 8'(8'h01 + i);
    exp4.push_back(8'h95);
    for (int i = 1; i < 8; i++) exp4.push_back(8'h00);
    run4(8, -1);
    for (int i = 0; i < 8; i++) txb[i] = 8'(8'h11 + i);
    for (int i = 0; i < 8; i++) exp4.push_back(8'(8'h01 + i));
    run4(8, -1);
    repeat (2) @(negedge clk);
    sl_en = 1'b0;

    // Loopback, 3 bytes, tx_valid withheld 20 cycles before byte 2.
    txb[0] = 8'h12; txb[1] = 8'h34; txb[2] = 8'h56;
    exp4.push_back(8'h12); exp4.push_back(8'h34); exp4.push_back(8'h56);
    run4(3, 1);
    // start presented in the done cycle must be ignored
    if4.i_num_bytes = 4'd1; if4.i_start = 1'b1;
    @(negedge clk);
    if4.i_start = 1'b0;
    chk("start_in_done_busy", 32'(if4.o_busy), 32'd0);
    chk("start_in_done_csb",  32'(if4.o_cs_b), 32'd1);

    // Illegal byte counts.
    foreach (txb[i]) txb[i] = 8'h00;
    for (int t = 0; t < 2; t++) begin
      d0 = n_done4; bad = 1'b0;
      @(negedge clk);
      if4.i_num_bytes = (t == 0) ? 4'd0 : 4'd9; if4.i_start = 1'b1;
      @(negedge clk);
      if4.i_start = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (if4.o_busy || !if4.o_cs_b) bad = 1'b1;
        @(negedge clk);
      end
      chk("bad_nb_quiet", 32'(bad), 32'd0);
      chk("bad_nb_done",  32'(n_done4 - d0), 32'd0);
    end

    // Reset after five rising sclk edges of the first byte.
    r0 = rises4; v0 = n_rxv4; d0 = n_done4;
    @(negedge clk);
    if4.i_num_bytes = 4'd1; if4.i_start = 1'b1;
    @(negedge clk);
    if4.i_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (if4.o_tx_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("rst_case_ready", 32'(ok), 32'd1);
    if4.i_tx_data = 8'hF8; if4.i_tx_valid = 1'b1;
    @(negedge clk);
    if4.i_tx_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rises4 - r0 >= 5) begin ok = 1'b1; break; end
    end
    chk("rst_case_5rises", 32'(ok), 32'd1);
    chk("rst_case_mosi_hi", 32'(if4.o_mosi), 32'd1);
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    chk("mid_rst_cs_b",     32'(if4.o_cs_b),     32'd1);
    chk("mid_rst_sclk",     32'(if4.o_sclk),     32'd0);
    chk("mid_rst_mosi",     32'(if4.o_mosi),     32'd0);
    chk("mid_rst_busy",     32'(if4.o_busy),     32'd0);
    chk("mid_rst_done",     32'(if4.o_done),     32'd0);
    chk("mid_rst_tx_ready", 32'(if4.o_tx_ready), 32'd0);
    chk("mid_rst_rx_valid", 32'(if4.o_rx_valid), 32'd0);
    chk("mid_rst_rx_data",  32'(if4.o_rx_data),  32'd0);
    repeat (60) @(negedge clk);
    chk("mid_rst_no_rxv",  32'(n_rxv4 - v0),  32'd0);
    chk("mid_rst_no_done", 32'(n_done4 - d0), 32'd0);
    txb[0] = 8'h69; exp4.push_back(8'h69);
    v0 = n_rxv4;
    run4(1, -1);
    @(negedge clk);
    chk("post_rst_rxvalid", 32'(n_rxv4 - v0), 32'd1);

    // CLK_DIV=1 instance, loopback 3C, C3.
    i0 = rise1_cyc.size(); d0 = n_done1; v0 = n_rxv1;
    exp1.push_back(8'h3C); exp1.push_back(8'hC3);
    @(negedge clk);
    if1.i_num_bytes = 4'd2; if1.i_start = 1'b1;
    @(negedge clk);
    if1.i_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (if1.o_tx_ready) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      chk("div1_ready", 32'(ok), 32'd1);
      if1.i_tx_data = (k == 0) ? 8'h3C : 8'hC3; if1.i_tx_valid = 1'b1;
      @(negedge clk);
      if1.i_tx_valid = 1'b0;
    end
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (if1.o_done) begin ok = 1'b1; break; end
    end
    chk("div1_done_seen", 32'(ok), 32'd1);
    @(negedge clk);
    chk("div1_rises", 32'(rise1_cyc.size() - i0), 32'd16);
    chk("div1_rxvalid", 32'(n_rxv1 - v0), 32'd2);
    if (rise1_cyc.size() >= i0 + 8) begin
      chk("div1_period",    32'(rise1_cyc[i0+1] - rise1_cyc[i0]), 32'd2);
      chk("div1_byte_span", 32'(rise1_cyc[i0+7] - rise1_cyc[i0]), 32'd14);
    end else
      chk("div1_rise_count", 32'(rise1_cyc.size() - i0), 32'd8);

    chk("exp4_drained", 32'(exp4.size()), 32'd0);
    chk("exp1_drained", 32'(exp1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
